// File: rtl/mips_lsu_bus_master.sv
// Load/store initiator between the MIPS pipeline and a word-wide data bus.
// Sub-word stores are performed as read-modify-write; bus words are byte-reversed.
module mips_lsu_bus_master #(
    parameter int BYTE_SWAP   = 1,
    parameter int ALIGN_CHECK = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] data_address,
    output logic        data_read,
    output logic        data_write,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]  state_q;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [15:0] wdata_q;
    logic [31:0] wr_word_q;
    logic [31:0] rdata_q;
    logic        store_q;
    logic        err_q;

    logic        req_legal;
    logic        req_misaligned;
    logic [31:0] rd_cpu;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;
    logic [31:0] merged_cpu;

    // Lane reversal is its own inverse, so it serves both bus->CPU and CPU->bus.
    function automatic logic [31:0] to_cpu(input logic [31:0] w);
        if (BYTE_SWAP != 0) return {w[7:0], w[15:8], w[23:16], w[31:24]};
        return w;
    endfunction

    always_comb begin
        req_legal = 1'b0;
        case (req_op)
            3'b000, 3'b001, 3'b011: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = !req_store;
            default:                req_legal = 1'b0;
        endcase
        req_misaligned = 1'b0;
        if (ALIGN_CHECK != 0) begin
            if (req_op[1:0] == 2'b01)      req_misaligned = req_addr[0];
            else if (req_op[1:0] == 2'b11) req_misaligned = |req_addr[1:0];
        end
    end

    always_comb begin
        rd_cpu  = to_cpu(data_readdata);
        rd_byte = rd_cpu[{addr_q[1:0], 3'b000} +: 8];
        rd_half = rd_cpu[{addr_q[1], 4'b0000} +: 16];
        case (op_q[1:0])
            2'b00:   load_val = op_q[2] ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_val = op_q[2] ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_val = rd_cpu;
        endcase
        merged_cpu = rd_cpu;
        if (op_q[1:0] == 2'b00) merged_cpu[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else                    merged_cpu[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_word_q <= '0;
            rdata_q   <= '0;
            store_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata[15:0];
                        store_q   <= req_store;
                        rdata_q   <= '0;
                        wr_word_q <= to_cpu(req_wdata);
                        err_q     <= !req_legal || req_misaligned;
                        if (!req_legal || req_misaligned)          state_q <= RESP;
                        else if (req_store && req_op[1:0] == 2'b11) state_q <= WR;
                        else                                        state_q <= RD;
                    end
                end
                RD: begin
                    if (store_q) begin
                        wr_word_q <= to_cpu(merged_cpu);
                        state_q   <= WR;
                    end else begin
                        rdata_q <= load_val;
                        state_q <= RESP;
                    end
                end
                WR:      state_q <= RESP;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready      = (state_q == IDLE);
    assign resp_valid     = (state_q == RESP);
    assign resp_rdata     = resp_valid ? rdata_q : '0;
    assign resp_err       = resp_valid & err_q;
    assign data_read      = (state_q == RD);
    assign data_write     = (state_q == WR);
    assign data_address   = {addr_q[31:2], 2'b00};
    assign data_writedata = wr_word_q;

endmodule
